// File: rtl/lfsr_ctrl.sv
// rtl/lfsr_ctrl.sv - Seed sequencing, period measurement and round-robin sharing for one lfsr instance
module lfsr_ctrl #(
    parameter int          WIDTH        = 64,
    parameter logic [63:0] DEFAULT_SEED = 64'h0006_7600_0464_6400,
    parameter int          PERIOD_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                seed_valid,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [WIDTH-1:0]    lfsr_seed,
    output logic                lfsr_reset,
    input  logic [WIDTH-1:0]    lfsr_q,
    input  logic [1:0]          req,
    output logic [1:0]          gnt,
    output logic [WIDTH-1:0]    rnd_data,
    output logic                seed_err,
    output logic                period_done,
    output logic [PERIOD_W-1:0] period,
    output logic                period_ovf,
    output logic                busy
);

    localparam logic [WIDTH-1:0]    SEED_DEF = DEFAULT_SEED[WIDTH-1:0];
    localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_seed;
    logic [WIDTH-1:0]    r_first;
    logic                r_armed;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_done;
    logic                r_ovf;
    logic                r_seed_err;
    logic [1:0]          r_gnt;
    logic [WIDTH-1:0]    r_rnd;
    logic                r_ptr;

    logic w_seed_req;
    logic w_seed_zero;
    logic w_lockout;
    logic w_measure;
    logic w_grant_en;
    logic w_win;

    assign w_seed_req  = seed_valid && (r_state != S_LOAD);
    assign w_seed_zero = (seed_in == '0);
    assign w_lockout   = (r_state == S_RUN) && (lfsr_q == '0);
    assign w_measure   = (r_state == S_RUN) && !seed_valid && !w_lockout;
    assign w_grant_en  = w_measure && (req != 2'b00);

    // Contention goes to whoever did not win last; a lone requester always wins
    always_comb begin
        w_win = 1'b0;
        case (req)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_ptr;
            default: w_win = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_LOAD;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   if (seed_valid || w_lockout) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seed     <= SEED_DEF;
            r_first    <= '0;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_period   <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_seed_err <= 1'b0;
            r_gnt      <= 2'b00;
            r_rnd      <= '0;
            r_ptr      <= 1'b1;
        end else begin
            r_seed_err <= 1'b0;
            r_done     <= 1'b0;
            r_gnt      <= 2'b00;

            if (w_seed_req) begin
                r_seed     <= w_seed_zero ? SEED_DEF : seed_in;
                r_seed_err <= w_seed_zero;
            end else if (r_state == S_IDLE) begin
                r_seed <= SEED_DEF;
            end else if (w_lockout) begin
                r_seed     <= SEED_DEF;
                r_seed_err <= 1'b1;
            end

            // Saturation freezes the counter and disables repeat detection until reload
            if (r_state == S_LOAD) begin
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
                r_armed <= 1'b0;
            end else if (w_measure) begin
                if (!r_armed) begin
                    r_first <= lfsr_q;
                    r_cnt   <= '0;
                    r_armed <= 1'b1;
                end else if (!r_ovf) begin
                    if (r_cnt == CNT_MAX) begin
                        r_ovf <= 1'b1;
                    end else if ((r_cnt != '0) && (lfsr_q == r_first)) begin
                        r_period <= r_cnt + 1'b1;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            if (w_grant_en) begin
                r_gnt <= w_win ? 2'b10 : 2'b01;
                r_rnd <= lfsr_q;
                r_ptr <= w_win;
            end
        end
    end

    assign lfsr_seed   = r_seed;
    assign lfsr_reset  = (r_state != S_RUN);
    assign busy        = (r_state == S_LOAD);
    assign gnt         = r_gnt;
    assign rnd_data    = r_rnd;
    assign seed_err    = r_seed_err;
    assign period_done = r_done;
    assign period      = r_period;
    assign period_ovf  = r_ovf;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb/tb_lfsr_ctrl.sv - Directed self-checking bench for lfsr_ctrl with a 4-bit x^4+x^3+1 LFSR model
module tb_lfsr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        force_zero = 1'b0;
    int          errors = 0;
    int          checks = 0;

    logic        seed_valid = 1'b0;
    logic [3:0]  seed_in = 4'h0;
    logic [3:0]  lfsr_seed, lfsr_q, rnd_data, m_q;
    logic        lfsr_reset, seed_err, period_done, period_ovf, busy;
    logic [1:0]  req = 2'b00;
    logic [1:0]  gnt;
    logic [31:0] period;

    logic        seed_valid2 = 1'b0;
    logic [3:0]  seed_in2 = 4'h0;
    logic [3:0]  lfsr_seed2, lfsr_q2, rnd_data2, m_q2;
    logic        lfsr_reset2, seed_err2, period_done2, period_ovf2, busy2;
    logic [1:0]  gnt2;
    logic [2:0]  period2;

    always #5 clk = ~clk;

    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    always @(posedge clk) m_q  <= lfsr_reset  ? lfsr_seed  : lfsr_next(m_q);
    always @(posedge clk) m_q2 <= lfsr_reset2 ? lfsr_seed2 : lfsr_next(m_q2);
    assign lfsr_q  = force_zero ? 4'h0 : m_q;
    assign lfsr_q2 = m_q2;

    lfsr_ctrl #(.WIDTH(4), .DEFAULT_SEED(64'h9), .PERIOD_W(32)) u_dut (
        .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed_in(seed_in),
        .lfsr_seed(lfsr_seed), .lfsr_reset(lfsr_reset), .lfsr_q(lfsr_q),
        .req(req), .gnt(gnt), .rnd_data(rnd_data), .seed_err(seed_err),
        .period_done(period_done), .period(period), .period_ovf(period_ovf), .busy(busy)
    );

    lfsr_ctrl #(.WIDTH(4), .DEFAULT_SEED(64'h9), .PERIOD_W(3)) u_dut_ovf (
        .clk(clk), .reset(reset), .seed_valid(seed_valid2), .seed_in(seed_in2),
        .lfsr_seed(lfsr_seed2), .lfsr_reset(lfsr_reset2), .lfsr_q(lfsr_q2),
        .req(2'b00), .gnt(gnt2), .rnd_data(rnd_data2), .seed_err(seed_err2),
        .period_done(period_done2), .period(period2), .period_ovf(period_ovf2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        checks++; if (lfsr_reset !== 1'b1) begin errors++; $display("FAIL rst_lfsr_reset got %0h exp 1", lfsr_reset); end
        checks++; if (lfsr_seed !== 4'h9) begin errors++; $display("FAIL rst_lfsr_seed got %0h exp 9", lfsr_seed); end
        checks++; if (gnt !== 2'b00 || rnd_data !== 4'h0) begin errors++; $display("FAIL rst_gnt_data got %0h/%0h exp 0/0", gnt, rnd_data); end
        checks++; if (seed_err !== 1'b0 || period_done !== 1'b0 || period_ovf !== 1'b0) begin errors++; $display("FAIL rst_flags got %0b%0b%0b exp 000", seed_err, period_done, period_ovf); end
        checks++; if (period !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_period_busy got %0d/%0b exp 0/0", period, busy); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b1 || lfsr_seed !== 4'h9 || lfsr_reset !== 1'b1 || gnt !== 2'b00) begin errors++; $display("FAIL idle_load got busy=%0b seed=%0h lr=%0b gnt=%0h exp 1/9/1/0", busy, lfsr_seed, lfsr_reset, gnt); end
        tick();
        checks++; if (busy !== 1'b0 || lfsr_reset !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL idle_run got busy=%0b lr=%0b gnt=%0h exp 0/0/0", busy, lfsr_reset, gnt); end
    endtask

    task automatic test_period();
        int found;
        seed_valid = 1'b1; seed_in = 4'h1;
        tick();
        seed_valid = 1'b0;
        checks++; if (busy !== 1'b1 || lfsr_seed !== 4'h1) begin errors++; $display("FAIL per_load got busy=%0b seed=%0h exp 1/1", busy, lfsr_seed); end
        tick();
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            tick();
            if (period_done) found = k;
        end
        checks++; if (found !== 16) begin errors++; $display("FAIL per_first_latency got %0d exp 16", found); end
        checks++; if (period !== 32'd15) begin errors++; $display("FAIL per_first_value got %0d exp 15", period); end
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            tick();
            if (k == 1) begin
                checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL per_pulse_width got %0b exp 0", period_done); end
            end
            if (period_done) found = k;
        end
        checks++; if (found !== 15) begin errors++; $display("FAIL per_second_spacing got %0d exp 15", found); end
        checks++; if (period !== 32'd15 || period_ovf !== 1'b0) begin errors++; $display("FAIL per_second_value got %0d ovf=%0b exp 15/0", period, period_ovf); end
    endtask

    task automatic test_seed_zero();
        seed_valid = 1'b1; seed_in = 4'h0;
        tick();
        seed_valid = 1'b0;
        checks++; if (seed_err !== 1'b1 || lfsr_seed !== 4'h9 || busy !== 1'b1) begin errors++; $display("FAIL zero_seed got err=%0b seed=%0h busy=%0b exp 1/9/1", seed_err, lfsr_seed, busy); end
        checks++; if (period !== 32'd15) begin errors++; $display("FAIL zero_period_hold got %0d exp 15", period); end
        tick();
        checks++; if (seed_err !== 1'b0 || busy !== 1'b0 || period !== 32'd15) begin errors++; $display("FAIL zero_after got err=%0b busy=%0b per=%0d exp 0/0/15", seed_err, busy, period); end
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_d;
        logic [1:0] exp_g;
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_d = m_q;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++; if (gnt !== exp_g || rnd_data !== exp_d) begin errors++; $display("FAIL arb_alt_%0d got gnt=%0b data=%0h exp %0b/%0h", i, gnt, rnd_data, exp_g, exp_d); end
        end
        req = 2'b00;
        tick();
        checks++; if (gnt !== 2'b00 || rnd_data !== exp_d) begin errors++; $display("FAIL arb_idle_hold got gnt=%0b data=%0h exp 00/%0h", gnt, rnd_data, exp_d); end
        req = 2'b10;
        tick(); tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL arb_single got gnt=%0b exp 10", gnt); end
        req = 2'b11;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL arb_after_single got gnt=%0b exp 01", gnt); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_d;
        req = 2'b11; seed_valid = 1'b1; seed_in = 4'h5;
        tick();
        seed_valid = 1'b0;
        checks++; if (gnt !== 2'b00 || busy !== 1'b1 || lfsr_seed !== 4'h5 || seed_err !== 1'b0) begin errors++; $display("FAIL b2b_load got gnt=%0b busy=%0b seed=%0h err=%0b exp 00/1/5/0", gnt, busy, lfsr_seed, seed_err); end
        tick();
        checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL b2b_run0 got gnt=%0b busy=%0b exp 00/0", gnt, busy); end
        exp_d = m_q;
        tick();
        checks++; if (gnt !== 2'b10 || rnd_data !== exp_d || exp_d !== 4'h5) begin errors++; $display("FAIL b2b_resume got gnt=%0b data=%0h exp 10/5", gnt, rnd_data); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_lockout();
        force_zero = 1'b1; seed_valid = 1'b1; seed_in = 4'h3;
        tick();
        seed_valid = 1'b0; force_zero = 1'b0;
        checks++; if (busy !== 1'b1 || lfsr_seed !== 4'h3 || seed_err !== 1'b0) begin errors++; $display("FAIL lock_vs_seed got busy=%0b seed=%0h err=%0b exp 1/3/0", busy, lfsr_seed, seed_err); end
        tick();
        force_zero = 1'b1;
        tick();
        force_zero = 1'b0;
        checks++; if (busy !== 1'b1 || lfsr_seed !== 4'h9 || seed_err !== 1'b1 || lfsr_reset !== 1'b1) begin errors++; $display("FAIL lock_recover got busy=%0b seed=%0h err=%0b lr=%0b exp 1/9/1/1", busy, lfsr_seed, seed_err, lfsr_reset); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || lfsr_reset !== 1'b1 || lfsr_seed !== 4'h9 || seed_err !== 1'b0) begin errors++; $display("FAIL load_reset_ctl got busy=%0b lr=%0b seed=%0h err=%0b exp 0/1/9/0", busy, lfsr_reset, lfsr_seed, seed_err); end
        checks++; if (period !== 32'd0 || gnt !== 2'b00 || rnd_data !== 4'h0 || period_ovf !== 1'b0 || period_done !== 1'b0) begin errors++; $display("FAIL load_reset_dp got per=%0d gnt=%0b data=%0h ovf=%0b done=%0b exp all 0", period, gnt, rnd_data, period_ovf, period_done); end
        reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_overflow();
        int found;
        int saw_done;
        for (int k = 0; k < 12; k++) tick();
        checks++; if (period_ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_default got %0b exp 1", period_ovf2); end
        seed_valid2 = 1'b1; seed_in2 = 4'h1;
        tick();
        seed_valid2 = 1'b0;
        tick();
        checks++; if (period_ovf2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL ovf_clear got ovf=%0b busy=%0b exp 0/0", period_ovf2, busy2); end
        found = 0; saw_done = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (period_done2) saw_done = 1;
            if (period_ovf2 && found == 0) found = k;
        end
        checks++; if (found !== 9) begin errors++; $display("FAIL ovf_latency got %0d exp 9", found); end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (period_done2) saw_done = 1;
        end
        checks++; if (saw_done !== 0 || period_ovf2 !== 1'b1 || period2 !== 3'd0) begin errors++; $display("FAIL ovf_no_done got done=%0d ovf=%0b per=%0d exp 0/1/0", saw_done, period_ovf2, period2); end
    endtask

    initial begin
        test_reset();
        test_period();
        test_seed_zero();
        test_arbitration();
        test_back_to_back();
        test_lockout();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_ctrl.md
# lfsr_ctrl

Sequencing and sharing controller for the 64-bit `lfsr` datapath. It loads seeds, rejecting the all-zero lock-out seed, and holds the LFSR in its load/reset phase for exactly one cycle. It measures the sequence period against the first post-load value and arbitrates the free-running LFSR output between two requesters, round-robin. It sits between the game-board seeding logic (requester 0) and the test/diagnostic path (requester 1) on one side, and a single `lfsr` instance on the other.

## Interface
Parameters:
- `WIDTH`, 64, LFSR state width.
- `DEFAULT_SEED`, 64'h0006_7600_0464_6400 (truncated to `WIDTH`), substitute seed when the supplied seed is all-zero.
- `PERIOD_W`, 32, period counter width.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `seed_valid`  in  1  one-cycle request to load `seed_in`.
- `seed_in`  in  WIDTH  requested seed.
- `lfsr_seed`  out  WIDTH  seed driven to `lfsr.seed`.
- `lfsr_reset`  out  1  drives `lfsr.reset`; `lfsr` loads `lfsr_seed` on a clock edge while this is high.
- `lfsr_q`  in  WIDTH  `lfsr.shift_seed`; advances every clock while `lfsr_reset` is low.
- `req`  in  2  per-requester random-word request, level.
- `gnt`  out  2  one-hot grant, registered.
- `rnd_data`  out  WIDTH  word delivered with `gnt`.
- `seed_err`  out  1  one-cycle pulse: zero seed replaced, or lock-out recovered.
- `period_done`  out  1  one-cycle pulse: period measured.
- `period`  out  PERIOD_W  last measured period; holds until the next measurement.
- `period_ovf`  out  1  sticky: counter saturated without repeat; cleared on load.
- `busy`  out  1  high in `LOAD`.

## Operation
- States: `IDLE`, `LOAD`, `RUN`.
- Reset: state `IDLE`; `lfsr_reset`=1; `lfsr_seed`=`DEFAULT_SEED`; `gnt`=0; `rnd_data`=0; `seed_err`=0; `period_done`=0; `period`=0; `period_ovf`=0; `busy`=0; RR pointer=1, so requester 0 wins first.
- `IDLE` always moves to `LOAD` with the seed register=`DEFAULT_SEED`.
- `seed_valid` in `IDLE` or `RUN`:
  - Latch `seed_in` and go to `LOAD`.
  - If `seed_in`==0, latch `DEFAULT_SEED` instead and pulse `seed_err` next cycle.
  - `seed_valid` during `LOAD` is ignored.
- `LOAD` (exactly 1 cycle):
  - Outputs: `lfsr_reset`=1, `lfsr_seed`=latched seed, `busy`=1, `gnt`=0.
  - Clear period counter and `period_ovf`; go to `RUN`.
- `RUN`:
  - `lfsr_reset`=0.
  - First `RUN` cycle: capture `first`=`lfsr_q` (equals the loaded seed); counter=0.
  - Each later cycle: counter+1, saturating at 2^PERIOD_W-1.
  - If counter>0 and `lfsr_q`==`first`: `period`<=counter+1, pulse `period_done`, restart count (counter=0). Measurement repeats continuously.
  - On saturation: set `period_ovf`; stop comparing until the next load.
- Lock-out: `lfsr_q`==0 in `RUN` → pulse `seed_err`, seed register=`DEFAULT_SEED`, go to `LOAD`.
- Arbitration (in `RUN` only):
  - Each cycle with `req`≠0, grant one requester. Priority goes to the requester other than the RR pointer.
  - Registered outputs: `gnt`<=one-hot winner, `rnd_data`<=`lfsr_q`; pointer<=winner.
  - Both requesting → strict alternation, one word per cycle in total.
  - `req`==0 → `gnt`=0, `rnd_data` holds.
- Simultaneous events:
  - `seed_valid` and lock-out in the same cycle: `seed_valid` wins. `seed_err` pulses only if `seed_in`==0.
  - `seed_valid` with active `req` in the same cycle: no grant that cycle; arbitration resumes 2 cycles later.
- `reset` asserted in any state returns to the reset values on the next edge, mid-load or mid-measure included.

## Timing
- `seed_valid` at edge N → `LOAD` during cycle N+1 → `lfsr_q`=seed after edge N+2, first `RUN` cycle.
- Seed-load latency: 2 cycles from `seed_valid` to a valid sequence.
- Grant latency: `req` sampled at edge N → `gnt`/`rnd_data` valid after edge N; consumer samples at edge N+1.
- Throughput: one word per cycle total.
- `period_done` asserts the cycle after the repeat is observed.
- Word-to-word uniqueness holds only while `lfsr` advances every cycle.

## Test plan
- Reset, release, no `seed_valid` → one cycle with `busy`=1 and `lfsr_seed`=`DEFAULT_SEED`, then `RUN`; `gnt`=0 throughout.
- `WIDTH`=4, bench LFSR model x^4+x^3+1, `seed_in`=4'h1 → `period_done` pulses with `period`=15, and again 15 cycles later; `period_ovf`=0.
- `seed_in`=0 → `seed_err` one-cycle pulse; `lfsr_seed`=`DEFAULT_SEED`; `period` unaffected until the next measurement.
- `req`=2'b11 held for 6 cycles → `gnt` sequence 01,10,01,10,01,10; each `rnd_data` equals the model's `lfsr_q` one cycle earlier.
- `PERIOD_W`=3, `WIDTH`=4 LFSR with period 15 → `period_ovf`=1 after 7 counts; no `period_done`; next `seed_valid` clears `period_ovf`.
- Force `lfsr_q`=0 in `RUN` → `seed_err` pulse, `LOAD` with `DEFAULT_SEED`. Assert `reset` during `LOAD` → all outputs at reset values next cycle.
